// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Fetch stage with an FQ_DEPTH-entry instruction queue. Owns the fetch PC,
// drives a synchronous-read instruction memory (one cycle read latency) and
// buffers returned instructions for ID, which drains them via valid/ready.
// A taken EX branch or an ID jump redirects fetch, flushing both the queue and
// the response that is in flight from the memory.
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   defined   : a redirect to a target with tgt[1:0]!=0 fetches the word at
//               tgt&~3, enqueues it with pc=tgt and misaligned=1, then stops
//               issuing until the next redirect or reset.
//   undefined : tgt[1:0] is forced to zero; o_if_misaligned is always 0.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_wen/i_waddr/
//   i_wdata             instruction memory byte-enabled write port
//   i_id_ready          ID accepts the head entry this cycle
//   i_ex_branch_taken/
//   i_ex_branch_tgt     EX branch redirect (wins over the ID jump)
//   i_id_jump/
//   i_id_jump_tgt       ID jump redirect
//   o_if_valid          head entry valid
//   o_if_instr/o_if_pc  head instruction and its PC
//   o_if_misaligned     head entry came from a misaligned redirect target
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int               XLEN     = 64,
    parameter int               ILEN     = 32,
    parameter int               IM_DEPTH = 1024,
    parameter int               FQ_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ILEN/8-1:0]           i_wen,
    input  logic [$clog2(IM_DEPTH)-1:0] i_waddr,
    input  logic [ILEN-1:0]             i_wdata,
    input  logic                        i_id_ready,
    input  logic                        i_ex_branch_taken,
    input  logic [XLEN-1:0]             i_ex_branch_tgt,
    input  logic                        i_id_jump,
    input  logic [XLEN-1:0]             i_id_jump_tgt,
    output logic                        o_if_valid,
    output logic [ILEN-1:0]             o_if_instr,
    output logic [XLEN-1:0]             o_if_pc,
    output logic                        o_if_misaligned
);

    localparam int IDX_W  = $clog2(IM_DEPTH);
    localparam int PTR_W  = $clog2(FQ_DEPTH);
    localparam int CNT_W  = $clog2(FQ_DEPTH + 1);
    localparam int NBYTES = ILEN / 8;

    logic [ILEN-1:0]  im_mem [IM_DEPTH];
    logic [ILEN-1:0]  im_rdata;

    logic [XLEN-1:0]  fetch_pc;
    logic             inflight;
    logic [XLEN-1:0]  inflight_pc;
    logic             inflight_mis;
    logic             halted;

    logic [ILEN-1:0]  q_instr [FQ_DEPTH];
    logic [XLEN-1:0]  q_pc    [FQ_DEPTH];
    logic             q_mis   [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [ILEN-1:0]  hold_instr;
    logic [XLEN-1:0]  hold_pc;
    logic             hold_mis;

    logic             redirect;
    logic [XLEN-1:0]  redirect_tgt;
    logic [XLEN-1:0]  tgt_fetch;
    logic [XLEN-1:0]  tgt_pc;
    logic             tgt_mis;
    logic             credit_ok;
    logic             issue_seq;
    logic             issue;
    logic [IDX_W-1:0] im_idx;
    logic             q_valid;
    logic             push;
    logic             pop;

    assign redirect     = i_ex_branch_taken | i_id_jump;
    assign redirect_tgt = i_ex_branch_taken ? i_ex_branch_tgt : i_id_jump_tgt;
    assign tgt_fetch    = redirect_tgt & ~XLEN'(3);

`ifdef IF_MISALIGN_CHECK_EN
    assign tgt_pc  = redirect_tgt;
    assign tgt_mis = |redirect_tgt[1:0];

    // A misaligned redirect delivers exactly one entry, then fetch stalls
    // until software/pipeline redirects again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (redirect) begin
            halted <= tgt_mis;
        end
    end
`else
    assign tgt_pc  = tgt_fetch;
    assign tgt_mis = 1'b0;
    assign halted  = 1'b0;
`endif

    // Credit counts the in-flight response as an occupied slot, so a response
    // can never arrive at a full queue. A same-cycle pop is deliberately not
    // counted as freed credit.
    assign credit_ok = (count + CNT_W'(inflight)) < CNT_W'(FQ_DEPTH);
    assign issue_seq = ~redirect & ~halted & ~(|i_wen) & credit_ok;
    assign issue     = redirect | issue_seq;
    assign im_idx    = redirect ? tgt_fetch[IDX_W+1:2] : fetch_pc[IDX_W+1:2];

    // A response arriving during a redirect cycle is wrong-path and dropped.
    assign q_valid = (count != '0);
    assign push    = inflight & ~redirect;
    assign pop     = q_valid & i_id_ready & ~redirect;

    // Instruction memory: byte-enabled write, registered read on issue.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (i_wen[b]) begin
                im_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (issue) begin
            im_rdata <= im_mem[im_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_mis <= 1'b0;
        end else if (redirect) begin
            fetch_pc     <= tgt_fetch + XLEN'(4);
            inflight     <= 1'b1;
            inflight_pc  <= tgt_pc;
            inflight_mis <= tgt_mis;
        end else if (issue_seq) begin
            fetch_pc     <= fetch_pc + XLEN'(4);
            inflight     <= 1'b1;
            inflight_pc  <= fetch_pc;
            inflight_mis <= 1'b0;
        end else begin
            inflight     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= im_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
            q_mis[wr_ptr]   <= inflight_mis;
        end
    end

    // Remember the last presented head so the payload holds while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr <= '0;
            hold_pc    <= '0;
            hold_mis   <= 1'b0;
        end else if (q_valid) begin
            hold_instr <= q_instr[rd_ptr];
            hold_pc    <= q_pc[rd_ptr];
            hold_mis   <= q_mis[rd_ptr];
        end
    end

    assign o_if_valid      = q_valid;
    assign o_if_instr      = q_valid ? q_instr[rd_ptr] : hold_instr;
    assign o_if_pc         = q_valid ? q_pc[rd_ptr]    : hold_pc;
    assign o_if_misaligned = q_valid ? q_mis[rd_ptr]   : hold_mis;

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue. IM[k]=k is loaded during reset, so the
// expected instruction for any PC below 4 KiB is pc>>2. Inputs change on the
// falling edge and outputs are sampled on the falling edge, away from the
// active rising edge. Honors IF_MISALIGN_CHECK_EN for the misaligned jump.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_wen;
    logic [9:0]  i_waddr;
    logic [31:0] i_wdata;
    logic        i_id_ready;
    logic        i_ex_branch_taken;
    logic [63:0] i_ex_branch_tgt;
    logic        i_id_jump;
    logic [63:0] i_id_jump_tgt;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [63:0] o_if_pc;
    logic        o_if_misaligned;

    int n_checks;
    int n_pass;

    if_fetch_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_wen             (i_wen),
        .i_waddr           (i_waddr),
        .i_wdata           (i_wdata),
        .i_id_ready        (i_id_ready),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_ex_branch_tgt   (i_ex_branch_tgt),
        .i_id_jump         (i_id_jump),
        .i_id_jump_tgt     (i_id_jump_tgt),
        .o_if_valid        (o_if_valid),
        .o_if_instr        (o_if_instr),
        .o_if_pc           (o_if_pc),
        .o_if_misaligned   (o_if_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic checkValid(input string tag, input logic exp_valid);
        checkValue({tag, ".valid"}, 64'(o_if_valid), 64'(exp_valid));
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] exp_pc,
                               input logic [31:0] exp_instr, input logic exp_mis);
        checkValue({tag, ".valid"}, 64'(o_if_valid), 64'd1);
        checkValue({tag, ".pc"},    o_if_pc,         exp_pc);
        checkValue({tag, ".instr"}, 64'(o_if_instr), 64'(exp_instr));
        checkValue({tag, ".mis"},   64'(o_if_misaligned), 64'(exp_mis));
    endtask

    task automatic applyStimulus(input logic ready, input logic br, input logic [63:0] br_tgt,
                                 input logic jmp, input logic [63:0] jmp_tgt);
        i_id_ready        = ready;
        i_ex_branch_taken = br;
        i_ex_branch_tgt   = br_tgt;
        i_id_jump         = jmp;
        i_id_jump_tgt     = jmp_tgt;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        i_wen    = '0;
        i_waddr  = '0;
        i_wdata  = '0;
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);

        // Load IM[k]=k while reset is held
        for (int k = 0; k < 1024; k++) begin
            tick();
            i_wen   = 4'hF;
            i_waddr = 10'(k);
            i_wdata = 32'(k);
        end
        tick();
        i_wen = '0;
        tick();
        checkValid("reset", 1'b0);
        checkValue("reset.pc",    o_if_pc,         64'h0);
        checkValue("reset.instr", 64'(o_if_instr), 64'h0);
        checkValue("reset.mis",   64'(o_if_misaligned), 64'h0);

        // Test 1: stream from RESET_PC, first valid two cycles after release
        rst_n = 1'b1;
        tick();
        checkValid("t1.c1", 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t1.s%0d", i), 64'(4*i), 32'(i), 1'b0);
        end

        // Test 2: stall 10 cycles, head held, then drain consecutively
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("t2.hold%0d", i), 64'hC, 32'd3, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("t2.drain%0d", i), 64'(16 + 4*i), 32'(4 + i), 1'b0);
        end

        // Test 3: branch to 0x100 with three entries queued
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        checkOutput("t3.pre", 64'h24, 32'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h100, 1'b0, 64'h0);
        tick();
        checkValid("t3.r1", 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        checkOutput("t3.r2", 64'h100, 32'h40, 1'b0);
        tick();
        checkOutput("t3.r3", 64'h104, 32'h41, 1'b0);
        tick();
        checkOutput("t3.r4", 64'h108, 32'h42, 1'b0);

        // Test 4: branch and jump together, branch wins
        applyStimulus(1'b1, 1'b1, 64'h200, 1'b1, 64'h300);
        tick();
        checkValid("t4.r1", 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        checkOutput("t4.r2", 64'h200, 32'h80, 1'b0);
        tick();
        checkOutput("t4.r3", 64'h204, 32'h81, 1'b0);
        tick();
        checkOutput("t4.r4", 64'h208, 32'h82, 1'b0);

        // Test 5: asynchronous reset mid-stream, then restart at RESET_PC
        #2 rst_n = 1'b0;
        #1;
        checkValid("t5.async", 1'b0);
        checkValue("t5.pc",    o_if_pc,         64'h0);
        checkValue("t5.instr", 64'(o_if_instr), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checkValid("t5.c1", 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t5.s%0d", i), 64'(4*i), 32'(i), 1'b0);
        end

        // IM write blocks one issue, leaving a one-cycle bubble
        i_wen   = 4'hF;
        i_waddr = 10'd3;
        i_wdata = 32'd3;
        tick();
        i_wen = '0;
        checkOutput("wen.s0", 64'hC, 32'd3, 1'b0);
        tick();
        checkValid("wen.bubble", 1'b0);
        tick();
        checkOutput("wen.s1", 64'h10, 32'd4, 1'b0);
        tick();
        checkOutput("wen.s2", 64'h14, 32'd5, 1'b0);

        // Test 6: jump to misaligned target 0x102
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 64'h102);
        tick();
        checkValid("t6.r1", 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
`ifdef IF_MISALIGN_CHECK_EN
        checkOutput("t6.r2", 64'h102, 32'h40, 1'b1);
        tick();
        checkValid("t6.halt1", 1'b0);
        tick();
        checkValid("t6.halt2", 1'b0);
`else
        checkOutput("t6.r2", 64'h100, 32'h40, 1'b0);
        tick();
        checkOutput("t6.r3", 64'h104, 32'h41, 1'b0);
        tick();
        checkOutput("t6.r4", 64'h108, 32'h42, 1'b0);
`endif
        // Redirect recovers normal streaming in either configuration
        applyStimulus(1'b1, 1'b1, 64'h10, 1'b0, 64'h0);
        tick();
        checkValid("t6.rec1", 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        checkOutput("t6.rec2", 64'h10, 32'd4, 1'b0);
        tick();
        checkOutput("t6.rec3", 64'h14, 32'd5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
